arb_word_mux: RTL and testbench



---
 rtl/arb_word_mux_pkg.sv | 28 ++
 rtl/arb_word_mux_onehot.sv | 22 ++
 rtl/arb_word_mux.sv | 101 ++++++++++
 tb/tb_arb_word_mux.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_word_mux_pkg.sv
// Shared helpers for the arbitrated word multiplexer: source-index width
// calculation and one-hot to binary index conversion.
package arb_mux_pkg;

    // Width of a source index: ceil(log2(n)), never less than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Binary index of the set bit in a one-hot vector of up to 32 bits.
    // An all-zero vector maps to index 0.
    function automatic logic [4:0] onehot_to_index(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_word_mux_onehot.sv
// AND-OR N:1 word selector driven by a one-hot (or all-zero) select.
// Purely combinational; an all-zero select yields an all-zero word.
module word_onehot_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4
) (
    input  logic [N_IN-1:0]       sel,
    input  logic [N_IN*WIDTH-1:0] data,
    output logic [WIDTH-1:0]      word
);

    // OR together every channel word masked by its select bit.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_IN; i++) begin
            word = word | (data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
        end
    end

endmodule

// File: rtl/arb_word_mux.sv
// N-channel arbitrated word multiplexer with valid/ready handshake on both
// sides and a single registered output stage (1 word/cycle throughput).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest-index requesting channel always wins.
module arb_word_mux
    import arb_mux_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N_IN  = 4,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic [N_IN-1:0]  grant;
    logic [SEL_W-1:0] grant_sel;
    logic [WIDTH-1:0] grant_word;
    logic             load_en;
    logic             in_xfer;
    logic             out_xfer;

`ifdef ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr;
    int               best_dist;

    // Round-robin pick: the valid channel closest after rr_ptr (wrapping) wins.
    always_comb begin
        grant     = '0;
        best_dist = N_IN;
        for (int i = 0; i < N_IN; i++) begin
            if (in_valid[i] && (((i + N_IN - 1 - int'(rr_ptr)) % N_IN) < best_dist)) begin
                best_dist = (i + N_IN - 1 - int'(rr_ptr)) % N_IN;
                grant     = '0;
                grant[i]  = 1'b1;
            end
        end
    end

    // Pointer remembers the last served channel; it moves only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_W'(N_IN - 1);
        end else if (in_xfer) begin
            rr_ptr <= grant_sel;
        end
    end
`else
    // Fixed-priority pick: scanning downward leaves the lowest valid index granted.
    always_comb begin
        grant = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

    assign grant_sel = SEL_W'(onehot_to_index(32'(grant)));

    // The output register can take a new word when empty or being drained this cycle.
    // in_ready is held low throughout reset.
    assign load_en  = ~out_valid | out_ready;
    assign in_ready = grant & {N_IN{load_en & rst_n}};
    assign in_xfer  = |(in_valid & in_ready);
    assign out_xfer = out_valid & out_ready;

    word_onehot_mux #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_data_mux (
        .sel   (grant),
        .data  (in_data),
        .word  (grant_word)
    );

    // Output register: load on an input transfer, otherwise empty out on an output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_word;
            out_sel   <= grant_sel;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_word_mux.sv
// Self-checking bench for arb_word_mux: a 4x32 instance exercised through
// reset, single-channel, backpressure, arbitration and async-reset scenarios,
// and a 1x8 instance streaming 256 bytes under random output stalls.
// Both instances are checked against a scoreboard of expected words.
module tb_arb_word_mux;

    logic         clk;
    logic         rst_n;

    logic [3:0]   in_valid;
    logic [31:0]  drv_data [4];
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic         in_valid1;
    logic [7:0]   in_data1;
    logic         in_ready1;
    logic         out_valid1;
    logic [7:0]   out_data1;
    logic         out_sel1;
    logic         out_ready1;

    int           errors;
    int           checks;

    logic [33:0]  sb4 [$];
    logic [7:0]   sb1 [$];
    int           grant_log [$];

    logic         mon_en;
    logic         m_valid;
    int           m_ptr;
    int           out_count;

    logic         mon1_en;
    logic         m_valid1;
    logic         acc1_flag;
    int           rx1;

    assign in_data = {drv_data[3], drv_data[2], drv_data[1], drv_data[0]};

    arb_word_mux #(
        .WIDTH (32),
        .N_IN  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    arb_word_mux #(
        .WIDTH (8),
        .N_IN  (1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .out_sel   (out_sel1),
        .out_ready (out_ready1)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream wedges
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report it when actual and expected differ
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    // Change the 4-channel handshake inputs just after a rising edge
    task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
        @(posedge clk);
        #1;
        in_valid  = valid;
        out_ready = rdy;
    endtask

    // Reference arbiter for the 4-channel instance; -1 means no request
    function automatic int model_pick(input logic [3:0] v, input int ptr);
`ifdef ARB_ROUND_ROBIN_EN
        for (int off = 1; off <= 4; off++) begin
            int idx;
            idx = (ptr + off) % 4;
            if (v[idx]) return idx;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // 4-channel monitor: predicts the transfers of the coming edge and scores outputs
    always @(negedge clk) begin
        if (mon_en) begin
            int         pick;
            logic       load;
            logic [3:0] exp_rdy;
            logic [33:0] item;
            pick    = model_pick(in_valid, m_ptr);
            load    = !m_valid || out_ready;
            exp_rdy = (pick >= 0 && load) ? (4'b0001 << pick) : 4'b0000;
            checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
            checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid && out_ready) begin
                if (sb4.size() == 0) begin
                    checkOutput("sb4_underflow", 64'(1), 64'(0));
                end else begin
                    item = sb4.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(item[31:0]));
                    checkOutput("out_sel", 64'(out_sel), 64'(item[33:32]));
                end
                out_count++;
            end
            if (exp_rdy != 4'b0000) begin
                sb4.push_back({2'(pick), drv_data[pick]});
                grant_log.push_back(pick);
                m_ptr = pick;
            end
            m_valid = (exp_rdy != 4'b0000) || (m_valid && !out_ready);
        end
    end

    // 1-channel monitor: same idea, with the accept flag handed back to the source
    always @(negedge clk) begin
        if (mon1_en) begin
            logic       exp_rdy1;
            logic [7:0] b;
            exp_rdy1 = in_valid1 && (!m_valid1 || out_ready1);
            checkOutput("in_ready1", 64'(in_ready1), 64'(exp_rdy1));
            checkOutput("out_valid1", 64'(out_valid1), 64'(m_valid1));
            if (m_valid1 && out_ready1) begin
                if (sb1.size() == 0) begin
                    checkOutput("sb1_underflow", 64'(1), 64'(0));
                end else begin
                    b = sb1.pop_front();
                    checkOutput("out_data1", 64'(out_data1), 64'(b));
                    checkOutput("out_sel1", 64'(out_sel1), 64'(0));
                end
                rx1++;
            end
            if (exp_rdy1) begin
                sb1.push_back(in_data1);
                acc1_flag = 1'b1;
            end
            m_valid1 = exp_rdy1 || (m_valid1 && !out_ready1);
        end
    end

    initial begin
        int c0;
        int cnt;
        int budget;
        int exp_seq [5];

        errors     = 0;
        checks     = 0;
        mon_en     = 1'b0;
        mon1_en    = 1'b0;
        m_valid    = 1'b0;
        m_ptr      = 3;
        out_count  = 0;
        m_valid1   = 1'b0;
        acc1_flag  = 1'b0;
        rx1        = 0;

        rst_n      = 1'b0;
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) drv_data[i] = 32'h1111_1111 * (i + 1);
        in_valid1  = 1'b0;
        in_data1   = 8'h00;
        out_ready1 = 1'b1;

        $display("[TB] reset with all channels requesting");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        checkOutput("rst_out_sel", 64'(out_sel), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        checkOutput("rst_out_valid1", 64'(out_valid1), 64'(0));

        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("first_grant", 64'(in_ready), 64'(4'b0001));

        $display("[TB] all channels valid, arbitration order");
        repeat (4) @(posedge clk);
        applyStimulus(4'b0000, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        checkOutput("grant_log_len", 64'(grant_log.size() >= 5), 64'(1));
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("grant_seq%0d", i), 64'(grant_log[i]), 64'(exp_seq[i]));
            end
        end
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);

        $display("[TB] single channel 2");
        applyStimulus(4'b0100, 1'b1);
        drv_data[2] = 32'hDEAD_BEEF;
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("ch2_out_valid", 64'(out_valid), 64'(1));
        checkOutput("ch2_out_data", 64'(out_data), 64'(32'hDEAD_BEEF));
        checkOutput("ch2_out_sel", 64'(out_sel), 64'(2));

        $display("[TB] backpressure then full throughput");
        applyStimulus(4'b0011, 1'b0);
        drv_data[0] = 32'hA0A0_0000;
        drv_data[1] = 32'hB1B1_0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
            checkOutput("stall_out_data", 64'(out_data), 64'(32'hDEAD_BEEF));
            checkOutput("stall_out_sel", 64'(out_sel), 64'(2));
        end
        applyStimulus(4'b0011, 1'b1);
        c0 = out_count;
        repeat (6) @(posedge clk);
        checkOutput("throughput", 64'(out_count - c0), 64'(6));

        $display("[TB] async reset mid-stream");
        #3;
        checkOutput("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'(0));
        checkOutput("async_out_data", 64'(out_data), 64'(0));
        checkOutput("async_in_ready", 64'(in_ready), 64'(0));
        sb4.delete();
        m_valid  = 1'b0;
        m_ptr    = 3;
        in_valid = 4'hF;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_restart_grant", 64'(in_ready), 64'(4'b0001));
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);

        $display("[TB] single-channel byte stream with stalls");
        @(posedge clk);
        #1;
        mon1_en   = 1'b1;
        cnt       = 0;
        in_data1  = 8'h00;
        in_valid1 = 1'b1;
        budget    = 0;
        while (rx1 < 256 && budget < 4000) begin
            @(posedge clk);
            #1;
            if (acc1_flag) begin
                acc1_flag = 1'b0;
                cnt++;
                if (cnt < 256) in_data1 = 8'(cnt);
                else           in_valid1 = 1'b0;
            end
            out_ready1 = ($urandom_range(0, 3) != 0);
            budget++;
        end
        checkOutput("stream_count", 64'(rx1), 64'(256));
        checkOutput("stream_sb_empty", 64'(sb1.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
